led_pulse_stretcher: RTL and testbench

- Output-side counterpart to the GPIO input conditioning path; sits between fabric/HPS event sources and board LEDs or output pins.
- Converts short event pulses (single-cycle or longer) into pulses with a guaranteed minimum active time and a minimum inactive gap.
- Queues events that arrive while a pulse is in progress, so bursts remain visible as separate blinks.
- One independent channel per bit.

---
 rtl/led_pulse_stretcher.sv | 184 ++++++++++++++++++
 tb/tb_led_pulse_stretcher.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/led_pulse_stretcher.sv
// Per-channel LED pulse stretcher: turns event rising edges into pulses with a
// guaranteed minimum on time and off gap, queueing events that arrive mid-pulse.

module led_pulse_stretcher_checker #(
  parameter int   WIDTH  = 4,
  parameter logic ACTIVE = 1'b1
) (
  input logic             clk,
  input logic             reset,
  input logic [WIDTH-1:0] data_out,
  input logic [WIDTH-1:0] busy
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_chk
    a_active_implies_busy: assert property (
      @(posedge clk) disable iff (reset)
      !(data_out[i] == ACTIVE) || busy[i]
    );
  end

endmodule

module led_pulse_stretcher #(
  parameter int    WIDTH         = 4,
  parameter string POLARITY      = "HIGH",
  parameter int    ON_TIME       = 50000,
  parameter int    OFF_TIME      = 50000,
  parameter int    TIMER_WIDTH   = 16,
  parameter int    PENDING_WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] event_in,
  input  logic [WIDTH-1:0] overflow_clr,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] busy,
  output logic [WIDTH-1:0] overflow
);

  localparam logic ACTIVE = (POLARITY == "LOW") ? 1'b0 : 1'b1;

  localparam logic [TIMER_WIDTH-1:0]   ON_LAST    = TIMER_WIDTH'(ON_TIME - 1);
  localparam logic [TIMER_WIDTH-1:0]   OFF_LAST   = TIMER_WIDTH'(OFF_TIME - 1);
  localparam logic [TIMER_WIDTH-1:0]   TIMER_ZERO = TIMER_WIDTH'(0);
  localparam logic [TIMER_WIDTH-1:0]   TIMER_ONE  = TIMER_WIDTH'(1);
  localparam logic [PENDING_WIDTH-1:0] PEND_ZERO  = PENDING_WIDTH'(0);
  localparam logic [PENDING_WIDTH-1:0] PEND_ONE   = PENDING_WIDTH'(1);
  localparam logic [PENDING_WIDTH-1:0] PEND_MAX   = {PENDING_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_t;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    state_t                   state_r;
    state_t                   state_s;
    logic [TIMER_WIDTH-1:0]   timer_r;
    logic [TIMER_WIDTH-1:0]   timer_s;
    logic [PENDING_WIDTH-1:0] pending_r;
    logic [PENDING_WIDTH-1:0] pending_s;
    logic                     prev_r;
    logic                     overflow_r;
    logic                     overflow_s;
    logic                     data_out_r;
    logic                     busy_r;
    logic                     edge_s;
    logic                     queue_s;
    logic                     drop_s;

    assign edge_s = event_in[i] & ~prev_r;

    // Next-state, timer and pending-queue decode for this channel
    always_comb begin
      state_s   = state_r;
      timer_s   = timer_r;
      pending_s = pending_r;
      queue_s   = 1'b0;
      drop_s    = 1'b0;

      case (state_r)
        ST_IDLE: begin
          timer_s = TIMER_ZERO;
          if (edge_s) begin
            state_s = ST_ON;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_ON: begin
          queue_s = edge_s;
          if (timer_r == ON_LAST) begin
            state_s = ST_OFF;
            timer_s = TIMER_ZERO;
          end else begin
            timer_s = timer_r + TIMER_ONE;
          end
        end
        ST_OFF: begin
          if (timer_r == OFF_LAST) begin
            timer_s = TIMER_ZERO;
            // A queued event and a fresh edge in the terminal cycle cancel out
            if (pending_r != PEND_ZERO) begin
              state_s = ST_ON;
              if (edge_s) begin
                pending_s = pending_r;
              end else begin
                pending_s = pending_r - PEND_ONE;
              end
            end else if (edge_s) begin
              state_s = ST_ON;
            end else begin
              state_s = ST_IDLE;
            end
          end else begin
            queue_s = edge_s;
            timer_s = timer_r + TIMER_ONE;
          end
        end
        default: begin
          state_s   = ST_IDLE;
          timer_s   = TIMER_ZERO;
          pending_s = PEND_ZERO;
        end
      endcase

      if (queue_s) begin
        if (pending_r == PEND_MAX) begin
          drop_s = 1'b1;
        end else begin
          pending_s = pending_r + PEND_ONE;
        end
      end else begin
        drop_s = 1'b0;
      end

      if (drop_s) begin
        overflow_s = 1'b1;
      end else if (overflow_clr[i]) begin
        overflow_s = 1'b0;
      end else begin
        overflow_s = overflow_r;
      end
    end

    // Channel state, edge history and output registers
    always_ff @(posedge clk) begin
      if (reset) begin
        state_r    <= ST_IDLE;
        timer_r    <= TIMER_ZERO;
        pending_r  <= PEND_ZERO;
        prev_r     <= 1'b1;
        overflow_r <= 1'b0;
        data_out_r <= ~ACTIVE;
        busy_r     <= 1'b0;
      end else begin
        state_r    <= state_s;
        timer_r    <= timer_s;
        pending_r  <= pending_s;
        prev_r     <= event_in[i];
        overflow_r <= overflow_s;
        // Outputs track the state register exactly, one flop each
        data_out_r <= (state_s == ST_ON) ? ACTIVE : ~ACTIVE;
        busy_r     <= (state_s != ST_IDLE);
      end
    end

    assign data_out[i] = data_out_r;
    assign busy[i]     = busy_r;
    assign overflow[i] = overflow_r;
  end

  led_pulse_stretcher_checker #(
    .WIDTH  (WIDTH),
    .ACTIVE (ACTIVE)
  ) u_checker (
    .clk      (clk),
    .reset    (reset),
    .data_out (data_out),
    .busy     (busy)
  );

endmodule

// File: tb/tb_led_pulse_stretcher.sv
// Directed bench for led_pulse_stretcher: ON_TIME=4, OFF_TIME=3, PENDING_WIDTH=2,
// with a HIGH- and a LOW-polarity instance sharing the same stimulus.

module tb_led_pulse_stretcher;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] event_in;
  logic [3:0] overflow_clr;
  logic [3:0] data_out;
  logic [3:0] busy;
  logic [3:0] overflow;
  logic [3:0] data_out_low;
  logic [3:0] busy_low;
  logic [3:0] overflow_low;

  int checks = 0;
  int errors = 0;

  logic [63:0] dout, dlow, bsy, ovf;

  always #5 clk = ~clk;

  led_pulse_stretcher #(
    .WIDTH(4), .POLARITY("HIGH"), .ON_TIME(4), .OFF_TIME(3),
    .TIMER_WIDTH(2), .PENDING_WIDTH(2)
  ) dut (
    .clk(clk), .reset(reset), .event_in(event_in), .overflow_clr(overflow_clr),
    .data_out(data_out), .busy(busy), .overflow(overflow)
  );

  led_pulse_stretcher #(
    .WIDTH(4), .POLARITY("LOW"), .ON_TIME(4), .OFF_TIME(3),
    .TIMER_WIDTH(2), .PENDING_WIDTH(2)
  ) dut_low (
    .clk(clk), .reset(reset), .event_in(event_in), .overflow_clr(overflow_clr),
    .data_out(data_out_low), .busy(busy_low), .overflow(overflow_low)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Bit k of a pattern is the input during cycle k; bit k of a trace is the output in cycle k+1.
  task automatic run_trace(input int ch, input logic [63:0] ev, input logic [63:0] clr,
                           input logic [63:0] rst, input int n,
                           output logic [63:0] t_dout, output logic [63:0] t_dlow,
                           output logic [63:0] t_bsy, output logic [63:0] t_ovf);
    t_dout = '0; t_dlow = '0; t_bsy = '0; t_ovf = '0;
    for (int k = 0; k < n; k++) begin
      event_in[ch]     = ev[k];
      overflow_clr[ch] = clr[k];
      reset            = rst[k];
      step();
      t_dout[k] = data_out[ch];
      t_dlow[k] = data_out_low[ch];
      t_bsy[k]  = busy[ch];
      t_ovf[k]  = overflow[ch];
    end
    event_in[ch]     = 1'b0;
    overflow_clr[ch] = 1'b0;
    reset            = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    event_in     = 4'b0010;
    overflow_clr = 4'b0000;
    repeat (3) step();
    check("reset_data_out", {60'd0, data_out}, 64'h0);
    check("reset_busy", {60'd0, busy}, 64'h0);
    check("reset_overflow", {60'd0, overflow}, 64'h0);
    check("reset_data_out_low", {60'd0, data_out_low}, 64'hF);

    // Input held high through reset must not register as an event
    reset = 1'b0;
    repeat (4) step();
    check("held_thru_reset_busy", {60'd0, busy}, 64'h0);
    check("held_thru_reset_dout", {60'd0, data_out}, 64'h0);
    event_in = 4'b0000;
    step();

    // Single one-cycle event on channel 0
    run_trace(0, 64'h1, 64'h0, 64'h0, 10, dout, dlow, bsy, ovf);
    check("single_dout", dout, 64'hF);
    check("single_busy", bsy, 64'h7F);
    check("single_dout_low", dlow, 64'h3F0);
    check("single_ovf", ovf, 64'h0);

    // Held input gives one pulse; release and re-assert gives a second
    run_trace(1, 64'h00CF_FFFF, 64'h0, 64'h0, 30, dout, dlow, bsy, ovf);
    check("held_dout", dout, 64'h03C0_000F);
    check("held_busy", bsy, 64'h1FC0_007F);

    // Three edges queued into back-to-back pulses with period 7
    run_trace(2, 64'h15, 64'h0, 64'h0, 24, dout, dlow, bsy, ovf);
    check("burst_dout", dout, 64'h3_C78F);
    check("burst_busy", bsy, 64'h1F_FFFF);

    // Queue saturates at 3; the edge in cycle 10 is dropped
    run_trace(3, 64'h555, 64'h0, 64'h0, 36, dout, dlow, bsy, ovf);
    check("ovf_dout", dout, 64'hF | (64'hF << 7) | (64'hF << 14) | (64'hF << 21) | (64'hF << 28));
    check("ovf_busy", bsy, 64'h7_FFFF_FFFF);
    check("ovf_flag", ovf, 64'hF_FFFF_FC00);

    run_trace(3, 64'h0, 64'h1, 64'h0, 2, dout, dlow, bsy, ovf);
    check("ovf_clr_alone", ovf, 64'h0);

    // Clear coinciding with a new drop: the set wins
    run_trace(3, 64'h555, 64'h400, 64'h0, 36, dout, dlow, bsy, ovf);
    check("ovf_set_wins", ovf, 64'hF_FFFF_FC00);

    run_trace(3, 64'h0, 64'h1, 64'h0, 2, dout, dlow, bsy, ovf);
    check("ovf_clr_again", ovf, 64'h0);

    // Edge exactly in the terminal OFF cycle with nothing pending: no IDLE gap
    run_trace(0, 64'h81, 64'h0, 64'h0, 16, dout, dlow, bsy, ovf);
    check("term_edge_dout", dout, 64'h78F);
    check("term_edge_busy", bsy, 64'h3FFF);

    // Reset in the second ON cycle with two events pending and input held high
    run_trace(2, 64'hF_FFD5, 64'h0, 64'h200, 20, dout, dlow, bsy, ovf);
    check("midreset_dout", dout, 64'h18F);
    check("midreset_busy", bsy, 64'h1FF);
    check("midreset_dout_low", dlow, 64'hF_FE70);

    // Queue was discarded: a fresh edge yields exactly one pulse
    run_trace(2, 64'h2, 64'h0, 64'h0, 12, dout, dlow, bsy, ovf);
    check("post_reset_dout", dout, 64'h1E);
    check("post_reset_busy", bsy, 64'hFE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
